y86_pipe_reg: RTL and testbench
===============================

Name: y86_pipe_reg

Overview:
- Parametrised pipeline register for the Y86-64 pipeline. It carries the stat/icode/ifun/rA/rB/valC/valP bundle between stages.
- Generalises the fixed decode-stage latch with:
  - configurable word width and stage depth (1..4 register stages),
  - stall (hold) and bubble (NOP injection) control,
  - an input valid qualifier,
  - saturating performance counters and a sticky control-conflict flag.
- Instanced at the F/D, D/E, E/M and M/W boundaries.

Parameters:
- WORD_W, 64, width of valC and valP.
- STAT_W, 2, width of stat.
- STAGES, 1, number of back-to-back register stages (legal 1..4); sets latency.
- NOP_ICODE, 4'h1, icode inserted on bubble or reset.
- BUB_STAT, 2'b00, stat value inserted on bubble or reset.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all stages this cycle.
- bubble  in  1  load a NOP into stage 0 this cycle.
- in_valid  in  1  the input bundle carries a real instruction.
- in_stat  in  STAT_W  stage status in.
- in_icode  in  4  instruction code in.
- in_ifun  in  4  function code in.
- in_rA  in  4  register A id in.
- in_rB  in  4  register B id in.
- in_valC  in  WORD_W  constant word in.
- in_valP  in  WORD_W  next PC in.
- out_valid  out  1  the output bundle is a real instruction.
- out_stat  out  STAT_W  stage status out.
- out_icode  out  4  instruction code out.
- out_ifun  out  4  function code out.
- out_rA  out  4  register A id out.
- out_rB  out  4  register B id out.
- out_valC  out  WORD_W  constant word out.
- out_valP  out  WORD_W  next PC out.
- stall_cnt  out  CNT_W  cycles with stall asserted (saturating).
- bubble_cnt  out  CNT_W  bubbles actually inserted (saturating).
- conflict  out  1  sticky flag: stall and bubble were seen together.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is asynchronous, active-low, on rst_n; the registers clear immediately on rst_n falling.
- Reset values:
  - Every stage holds the NOP bundle: stat=BUB_STAT, icode=NOP_ICODE, ifun=0, rA=4'hF, rB=4'hF, valC=0, valP=0, valid=0.
  - stall_cnt=0, bubble_cnt=0, conflict=0.
- Stage chain:
  - Stage 0 captures the inputs; stage k captures stage k-1; the out_* ports are driven directly from stage STAGES-1 registers.
  - Latency is STAGES cycles. There is no combinational path from in_* to out_*.
- Per-cycle priority, evaluated at each rising edge:
  1. stall=1: all stages hold their contents, whatever bubble is. If bubble=1 in the same cycle, conflict sets to 1 and bubble_cnt does not increment.
  2. stall=0, bubble=1: stage 0 loads the NOP bundle with valid=0. Stages 1..STAGES-1 shift normally. bubble_cnt increments.
  3. stall=0, bubble=0: stage 0 loads the in_* bundle with valid=in_valid. All stages shift.
- in_valid=0 with no stall and no bubble: the payload is captured as presented. Only valid is 0; the payload is not forced to NOP.
- Counters:
  - stall_cnt increments on every edge with stall=1, saturating at all-ones.
  - bubble_cnt saturates the same way.
  - Neither counter wraps.
- conflict: cleared only by reset.
- Reset mid-operation: all stages, counters and conflict return to their reset values on the same asynchronous event. Contents in flight are discarded, with no partial shift.
- First edge after rst_n rises: normal priority rules apply. The first captured bundle appears at the outputs STAGES edges later.
- STAGES outside 1..4: elaboration error via generate-time check.

Test Plan:
- Reset then pass-through, STAGES=1: present icode=3, rA=2, rB=5, valC=64'h10, valP=64'h1A, in_valid=1 -> the outputs match one edge later with out_valid=1.
- STAGES=3 streaming: feed valP=1,2,3,4 on consecutive edges -> out_valP shows 1 on the 3rd edge after the first capture, then 2, 3, 4 on successive edges.
- Stall with STAGES=2 and valP 7 then 8 loaded: hold stall=1 for 3 edges -> the outputs freeze at the current values, stall_cnt=3, and they resume in order when stall drops.
- Bubble: assert bubble for one edge while in_icode=6 -> the output shows icode=1, stat=0, out_valid=0 for one cycle; bubble_cnt=1.
- Simultaneous stall and bubble for one edge -> the contents are held, conflict=1, bubble_cnt unchanged, and conflict stays 1 until rst_n pulses low.
- Async reset with a sampled check:
  - Drop rst_n mid-cycle while the stages are full -> the outputs go to the NOP bundle before the next edge.
  - Counter saturation (CNT_W=4): 20 stall edges -> stall_cnt=15.

Source files
------------

// File: rtl/y86_pipe_reg.sv
// y86_pipe_reg: parametrised Y86-64 pipeline latch with stall/bubble control and perf counters
module y86_pipe_reg #(
  parameter int          WORD_W    = 64,
  parameter int          STAT_W    = 2,
  parameter int          STAGES    = 1,
  parameter logic [3:0]  NOP_ICODE = 4'h1,
  parameter logic [1:0]  BUB_STAT  = 2'b00,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [WORD_W-1:0] in_valP,
  output logic              out_valid,
  output logic [STAT_W-1:0] out_stat,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [3:0]        out_rA,
  output logic [3:0]        out_rB,
  output logic [WORD_W-1:0] out_valC,
  output logic [WORD_W-1:0] out_valP,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              conflict
);
  typedef struct packed {
    logic              v;
    logic [STAT_W-1:0] stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] valc;
    logic [WORD_W-1:0] valp;
  } bundle_t;
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("y86_pipe_reg: STAGES must be 1..4");
  end
  bundle_t w_nop, w_in;
  bundle_t r_stg [STAGES];
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;
  logic r_conflict;
  always_comb begin
    w_nop = '{v: 1'b0, stat: STAT_W'(BUB_STAT), icode: NOP_ICODE, ifun: 4'h0,
              ra: 4'hF, rb: 4'hF, valc: '0, valp: '0};
    w_in  = '{v: in_valid, stat: in_stat, icode: in_icode, ifun: in_ifun,
              ra: in_rA, rb: in_rB, valc: in_valC, valp: in_valP};
  end
  // a stall freezes the whole chain; a bubble only replaces what enters stage 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) r_stg[k] <= w_nop;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_conflict   <= 1'b0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(stall && !(&r_stall_cnt));
      if (stall && bubble) r_conflict <= 1'b1;
      if (!stall) begin
        r_stg[0] <= bubble ? w_nop : w_in;
        for (int k = 1; k < STAGES; k++) r_stg[k] <= r_stg[k-1];
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(bubble && !(&r_bubble_cnt));
      end
    end
  end
  assign out_valid  = r_stg[STAGES-1].v;
  assign out_stat   = r_stg[STAGES-1].stat;
  assign out_icode  = r_stg[STAGES-1].icode;
  assign out_ifun   = r_stg[STAGES-1].ifun;
  assign out_rA     = r_stg[STAGES-1].ra;
  assign out_rB     = r_stg[STAGES-1].rb;
  assign out_valC   = r_stg[STAGES-1].valc;
  assign out_valP   = r_stg[STAGES-1].valp;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign conflict   = r_conflict;
endmodule

// File: tb/tb_y86_pipe_reg.sv
// tb_y86_pipe_reg: four instances (STAGES 1/2/3, and 1 with 4-bit counters) on shared stimulus, scoreboard plus directed checks
module tb_y86_pipe_reg;
  localparam int BW = 2 + 16 + 128;
  logic clk = 1'b0;
  logic rst_n, stall, bubble, in_valid;
  logic [1:0]  in_stat;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC, in_valP;
  logic st_q;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) st_q <= stall;
  for (genvar g = 0; g < 4; g++) begin : g_d
    localparam int S  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 1;
    localparam int CW = (g == 3) ? 4 : 16;
    logic ov, cf;
    logic [1:0] ost;
    logic [3:0] oic, oif, ora, orb;
    logic [63:0] ovc, ovp;
    logic [CW-1:0] sc, bc;
    logic [BW-1:0] q[$];
    logic [BW-1:0] e;
    y86_pipe_reg #(.STAGES(S), .CNT_W(CW)) u (
      .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .in_valid(in_valid),
      .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
      .in_valC(in_valC), .in_valP(in_valP),
      .out_valid(ov), .out_stat(ost), .out_icode(oic), .out_ifun(oif), .out_rA(ora), .out_rB(orb),
      .out_valC(ovc), .out_valP(ovp), .stall_cnt(sc), .bubble_cnt(bc), .conflict(cf));
    always @(posedge clk)
      if (rst_n && !stall && !bubble && in_valid)
        q.push_back({in_stat, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP});
    always @(negedge rst_n) q.delete();
    always @(negedge clk)
      if (rst_n && ov && !st_q) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL mon%0d unexpected valid output valP=%h", g, ovp);
        end else begin
          e = q.pop_front();
          if ({ost, oic, oif, ora, orb, ovc, ovp} !== e) begin
            bad++;
            $display("FAIL mon%0d bundle got=%h exp=%h", g, {ost, oic, oif, ora, orb, ovc, ovp}, e);
          end
        end
      end
  end
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, a, x);
    end
  endtask
  task automatic drv(input logic v, input logic [1:0] st, input logic [3:0] ic, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    in_valid = v; in_stat = st; in_icode = ic; in_ifun = 4'h0;
    in_rA = ra; in_rB = rb; in_valC = vc; in_valP = vp;
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
    drv(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step(2);
    chk("rst_valid", g_d[0].ov, 0);
    chk("rst_icode", g_d[0].oic, 4'h1);
    chk("rst_rA", g_d[0].ora, 4'hF);
    chk("rst_rB", g_d[2].orb, 4'hF);
    chk("rst_valP", g_d[2].ovp, 0);
    chk("rst_cnt", {g_d[0].sc, g_d[0].bc, 31'd0, g_d[0].cf}, 0);
    rst_n = 1'b1;
    drv(1'b1, 2'd0, 4'h3, 4'h2, 4'h5, 64'h10, 64'h1A);
    step(1);
    chk("pass_valid", g_d[0].ov, 1);
    chk("pass_icode", g_d[0].oic, 4'h3);
    chk("pass_rA", g_d[0].ora, 4'h2);
    chk("pass_rB", g_d[0].orb, 4'h5);
    chk("pass_valC", g_d[0].ovc, 64'h10);
    chk("pass_valP", g_d[0].ovp, 64'h1A);
    chk("pass_s3_notyet", g_d[2].ov, 0);
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 2'd0, 4'h3, 4'h2, 4'h5, 64'h10, 64'(i));
      step(1);
      if (i == 2) chk("s3_first", g_d[2].ovp, 64'h1A);
      if (i >= 3) chk("s3_stream", g_d[2].ovp, 64'(i - 2));
    end
    drv(1'b0, 2'd0, 4'h2, 4'h1, 4'h1, 64'h0, 64'h55);
    step(1);
    chk("s3_stream3", g_d[2].ovp, 64'd3);
    chk("inv_valid", g_d[0].ov, 0);
    chk("inv_payload", g_d[0].ovp, 64'h55);
    chk("inv_icode", g_d[0].oic, 4'h2);
    step(1);
    chk("s3_stream4", g_d[2].ovp, 64'd4);
    step(2);
    drv(1'b1, 2'd0, 4'h3, 4'h2, 4'h5, 64'h0, 64'h7);
    step(1);
    drv(1'b1, 2'd0, 4'h3, 4'h2, 4'h5, 64'h0, 64'h8);
    step(1);
    chk("s2_pre", g_d[1].ovp, 64'h7);
    stall = 1'b1;
    drv(1'b1, 2'd0, 4'h3, 4'h2, 4'h5, 64'h0, 64'h9);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_hold_s2", g_d[1].ovp, 64'h7);
      chk("stall_hold_s1", g_d[0].ovp, 64'h8);
    end
    chk("stall_cnt3", g_d[1].sc, 3);
    chk("stall_cnt3_w4", g_d[3].sc, 3);
    stall = 1'b0;
    step(1);
    chk("resume_8", g_d[1].ovp, 64'h8);
    drv(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step(1);
    chk("resume_9", g_d[1].ovp, 64'h9);
    step(3);
    bubble = 1'b1;
    drv(1'b1, 2'd2, 4'h6, 4'h3, 4'h4, 64'h0, 64'h60);
    step(1);
    chk("bub_icode", g_d[0].oic, 4'h1);
    chk("bub_stat", g_d[0].ost, 2'd0);
    chk("bub_valid", g_d[0].ov, 0);
    chk("bub_rA", g_d[0].ora, 4'hF);
    chk("bub_valP", g_d[0].ovp, 0);
    chk("bub_cnt1", g_d[0].bc, 1);
    bubble = 1'b0;
    drv(1'b1, 2'd2, 4'h6, 4'h3, 4'h4, 64'h0, 64'h61);
    step(1);
    chk("post_bub_icode", g_d[0].oic, 4'h6);
    chk("post_bub_valid", g_d[0].ov, 1);
    stall = 1'b1; bubble = 1'b1;
    drv(1'b1, 2'd0, 4'h2, 4'h1, 4'h1, 64'h0, 64'h70);
    step(1);
    chk("conf_hold", g_d[0].ovp, 64'h61);
    chk("conf_set", g_d[0].cf, 1);
    chk("conf_bubcnt", g_d[0].bc, 1);
    stall = 1'b0; bubble = 1'b0;
    drv(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step(4);
    chk("conf_sticky", g_d[2].cf, 1);
    chk("stall_cnt4", g_d[0].sc, 4);
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 2'd0, 4'h3, 4'h2, 4'h5, 64'h0, 64'hA0 + 64'(i));
      step(1);
    end
    chk("full_s3", g_d[2].ovp, 64'hA1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", g_d[2].ov, 0);
    chk("arst_icode", g_d[2].oic, 4'h1);
    chk("arst_valP", g_d[2].ovp, 0);
    chk("arst_rA", g_d[1].ora, 4'hF);
    chk("arst_conf", g_d[0].cf, 0);
    chk("arst_cnts", {g_d[0].sc, g_d[0].bc}, 0);
    drv(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    stall = 1'b1;
    step(20);
    chk("sat_w4", g_d[3].sc, 15);
    chk("sat_w16", g_d[0].sc, 20);
    stall = 1'b0;
    step(6);
    for (int g = 0; g < 4; g++) begin
      case (g)
        0: chk("sb_empty0", 64'(g_d[0].q.size()), 0);
        1: chk("sb_empty1", 64'(g_d[1].q.size()), 0);
        2: chk("sb_empty2", 64'(g_d[2].q.size()), 0);
        default: chk("sb_empty3", 64'(g_d[3].q.size()), 0);
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
